// File: rtl/tournament_bpred_pkg.sv
// tournament_bpred_pkg: in-flight metadata type and saturating counter helpers
package tournament_bpred_pkg;
  localparam int unsigned IDX_W = 16;
  typedef struct packed {
    logic [IDX_W-1:0] lidx;
    logic [IDX_W-1:0] lhist;
    logic [IDX_W-1:0] gidx;
    logic [IDX_W-1:0] cidx;
    logic lp;
    logic gp;
    logic fin;
  } meta_t;
  function automatic int unsigned ctr_init(input int unsigned bits);
    return (32'd1 << (bits - 1)) - 1;
  endfunction
  function automatic int unsigned sat_inc(input int unsigned c, input int unsigned bits);
    return (c == (32'd1 << bits) - 1) ? c : c + 1;
  endfunction
  function automatic int unsigned sat_dec(input int unsigned c);
    return (c == 0) ? c : c - 1;
  endfunction
endpackage

// File: rtl/tournament_bpred_metaq.sv
// tournament_bpred_metaq: in-flight prediction metadata fifo with push/pop/clear
module tournament_bpred_metaq
  import tournament_bpred_pkg::*;
#(
  parameter int unsigned INFLIGHT = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  meta_t din,
  input  logic  pop,
  input  logic  clear,
  output meta_t head,
  output logic  full,
  output logic  empty
);
  localparam int unsigned PW = $clog2(INFLIGHT);
  localparam int unsigned CW = PW + 1;
  meta_t mem [INFLIGHT];
  logic [PW-1:0] wr, rd;
  logic [CW-1:0] cnt;
  assign full = cnt == CW'(INFLIGHT);
  assign empty = cnt == '0;
  assign head = mem[rd];
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else if (clear) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      wr <= wr + PW'(push);
      rd <= rd + PW'(pop);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/tournament_bpred.sv
// tournament_bpred: local/gshare tournament predictor with in-flight queue, optional stats via TOURNAMENT_BPRED_STATS_EN
module tournament_bpred
  import tournament_bpred_pkg::*;
#(
  parameter int unsigned LHT_ENTRIES = 64,
  parameter int unsigned LHIST_BITS  = 10,
  parameter int unsigned GHIST_BITS  = 12,
  parameter int unsigned CTR_BITS    = 2,
  parameter int unsigned INFLIGHT    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  output logic        pred_ready,
  output logic        pred_taken,
  output logic        pred_sel,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic        flush,
  output logic        res_mispredict
`ifdef TOURNAMENT_BPRED_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);
  localparam int unsigned LW = $clog2(LHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] INIT = CTR_BITS'(ctr_init(CTR_BITS));
  logic [LHIST_BITS-1:0] lht [LHT_ENTRIES];
  logic [CTR_BITS-1:0] lpt [2**LHIST_BITS];
  logic [CTR_BITS-1:0] gpt [2**GHIST_BITS];
  logic [CTR_BITS-1:0] cpt [2**GHIST_BITS];
  logic [GHIST_BITS-1:0] spec_ghr, commit_ghr, commit_nx, gidx, h_gidx, h_cidx;
  logic [LHIST_BITS-1:0] lhist, h_lhist;
  logic [LW-1:0] lidx, h_lidx;
  logic [CTR_BITS-1:0] lpt_nx, gpt_nx, cpt_nx;
  logic lp, gp, full, empty, accept, resolve, repair, unused_ok;
  meta_t head, entry;
  assign lidx = pred_pc[LW+1:2];
  assign lhist = lht[lidx];
  assign gidx = spec_ghr ^ pred_pc[GHIST_BITS+1:2];
  assign lp = lpt[lhist][CTR_BITS-1];
  assign gp = gpt[gidx][CTR_BITS-1];
  assign pred_sel = cpt[spec_ghr][CTR_BITS-1];
  assign pred_taken = pred_sel ? gp : lp;
  assign res_mispredict = res_valid & !empty & (head.fin != res_taken);
  assign pred_ready = !full & !flush & !res_mispredict;
  assign accept = pred_valid & pred_ready;
  assign resolve = res_valid & !empty;
  assign repair = flush | res_mispredict;
  assign commit_nx = resolve ? {commit_ghr[GHIST_BITS-2:0], res_taken} : commit_ghr;
  assign entry = '{IDX_W'(lidx), IDX_W'(lhist), IDX_W'(gidx), IDX_W'(spec_ghr), lp, gp, pred_taken};
  assign h_lidx = LW'(head.lidx);
  assign h_lhist = LHIST_BITS'(head.lhist);
  assign h_gidx = GHIST_BITS'(head.gidx);
  assign h_cidx = GHIST_BITS'(head.cidx);
  assign lpt_nx = CTR_BITS'(res_taken ? sat_inc(32'(lpt[h_lhist]), CTR_BITS) : sat_dec(32'(lpt[h_lhist])));
  assign gpt_nx = CTR_BITS'(res_taken ? sat_inc(32'(gpt[h_gidx]), CTR_BITS) : sat_dec(32'(gpt[h_gidx])));
  assign cpt_nx = CTR_BITS'((head.gp == res_taken) ? sat_inc(32'(cpt[h_cidx]), CTR_BITS) : sat_dec(32'(cpt[h_cidx])));
  assign unused_ok = ^{pred_pc, head};
  tournament_bpred_metaq #(.INFLIGHT(INFLIGHT)) u_metaq (
    .clk  (clk),
    .rst_n(rst_n),
    .push (accept),
    .din  (entry),
    .pop  (resolve),
    .clear(repair),
    .head (head),
    .full (full),
    .empty(empty)
  );
  for (genvar i = 0; i < LHT_ENTRIES; i++) begin : g_lht
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) lht[i] <= '0;
      else if (resolve && h_lidx == LW'(i)) lht[i] <= {h_lhist[LHIST_BITS-2:0], res_taken};
  end
  for (genvar i = 0; i < 2**LHIST_BITS; i++) begin : g_lpt
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) lpt[i] <= INIT;
      else if (resolve && h_lhist == LHIST_BITS'(i)) lpt[i] <= lpt_nx;
  end
  for (genvar i = 0; i < 2**GHIST_BITS; i++) begin : g_gct
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        gpt[i] <= INIT;
        cpt[i] <= INIT;
      end else if (resolve) begin
        if (h_gidx == GHIST_BITS'(i)) gpt[i] <= gpt_nx;
        if (h_cidx == GHIST_BITS'(i) && head.lp != head.gp) cpt[i] <= cpt_nx;
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      spec_ghr <= '0;
      commit_ghr <= '0;
    end else begin
      commit_ghr <= commit_nx;
      spec_ghr <= repair ? commit_nx : accept ? {spec_ghr[GHIST_BITS-2:0], pred_taken} : spec_ghr;
    end
`ifdef TOURNAMENT_BPRED_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_branches <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve && stat_branches != '1) stat_branches <= stat_branches + 32'd1;
      if (res_mispredict && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
`endif
endmodule

// File: tb/tb_tournament_bpred.sv
// tb_tournament_bpred: randomized and directed checks against a behavioural tournament predictor model
module tb_tournament_bpred;
  localparam int LHTN = 64, L = 10, G = 12, C = 2, Q = 4;
  localparam int LN = 1 << L, GN = 1 << G, HALF = 1 << (C - 1), CMAX = (1 << C) - 1;
  logic clk = 0, rst_n = 0, pred_valid = 0, res_valid = 0, res_taken = 0, flush = 0;
  logic [31:0] pred_pc = 0;
  logic pred_ready, pred_taken, pred_sel, res_mispredict;
`ifdef TOURNAMENT_BPRED_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif
  int tests = 0, fails = 0;
  bit chk_en = 0;
  typedef struct {
    int lidx, lhist, gidx, cidx;
    bit lp, gp, fin;
  } ment_t;
  ment_t mq[$];
  int lht_m[LHTN];
  int lpt_m[LN];
  int gpt_m[GN];
  int cpt_m[GN];
  int spec_m, commit_m, br_m, mis_m;
  always #5 clk = ~clk;
  tournament_bpred #(
    .LHT_ENTRIES(LHTN), .LHIST_BITS(L), .GHIST_BITS(G), .CTR_BITS(C), .INFLIGHT(Q)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_ready(pred_ready), .pred_taken(pred_taken), .pred_sel(pred_sel),
    .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
    .res_mispredict(res_mispredict)
`ifdef TOURNAMENT_BPRED_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );
  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic ment_t mpred();
    ment_t e;
    int pcw = int'(pred_pc >> 2);
    e.lidx = pcw % LHTN;
    e.lhist = lht_m[e.lidx];
    e.lp = lpt_m[e.lhist] >= HALF;
    e.gidx = (spec_m ^ pcw) % GN;
    e.gp = gpt_m[e.gidx] >= HALF;
    e.cidx = spec_m;
    e.fin = (cpt_m[spec_m] >= HALF) ? e.gp : e.lp;
    return e;
  endfunction
  function automatic bit m_mis();
    return res_valid && mq.size() > 0 && mq[0].fin != res_taken;
  endfunction
  function automatic bit m_ready();
    return mq.size() < Q && !flush && !m_mis();
  endfunction
  function automatic int bump(input int v, input bit up);
    return up ? (v < CMAX ? v + 1 : v) : (v > 0 ? v - 1 : 0);
  endfunction
  task automatic mreset();
    foreach (lht_m[i]) lht_m[i] = 0;
    foreach (lpt_m[i]) lpt_m[i] = HALF - 1;
    foreach (gpt_m[i]) gpt_m[i] = HALF - 1;
    foreach (cpt_m[i]) cpt_m[i] = HALF - 1;
    mq.delete();
    spec_m = 0;
    commit_m = 0;
    br_m = 0;
    mis_m = 0;
  endtask
  always @(posedge clk or negedge rst_n) begin : model
    ment_t e, h;
    bit mis, acc;
    if (!rst_n) mreset();
    else begin
      e = mpred();
      mis = m_mis();
      acc = pred_valid && m_ready();
      if (res_valid && mq.size() > 0) begin
        h = mq.pop_front();
        lht_m[h.lidx] = ((h.lhist << 1) | int'(res_taken)) % LN;
        lpt_m[h.lhist] = bump(lpt_m[h.lhist], res_taken);
        gpt_m[h.gidx] = bump(gpt_m[h.gidx], res_taken);
        if (h.lp != h.gp) cpt_m[h.cidx] = bump(cpt_m[h.cidx], h.gp == res_taken);
        commit_m = ((commit_m << 1) | int'(res_taken)) % GN;
        br_m++;
        if (mis) mis_m++;
      end
      if (acc) begin
        mq.push_back(e);
        spec_m = ((spec_m << 1) | int'(e.fin)) % GN;
      end
      if (flush || mis) begin
        mq.delete();
        spec_m = commit_m;
      end
    end
  end
  always @(negedge clk) begin : compare
    ment_t e;
    if (rst_n && chk_en) begin
      e = mpred();
      chk("pred_ready", pred_ready, m_ready());
      chk("pred_taken", pred_taken, e.fin);
      chk("pred_sel", pred_sel, cpt_m[spec_m] >= HALF);
      chk("res_mispredict", res_mispredict, m_mis());
`ifdef TOURNAMENT_BPRED_STATS_EN
      chk("stat_branches", stat_branches, br_m);
      chk("stat_mispredicts", stat_mispredicts, mis_m);
`endif
    end
  end
  task automatic set_in(input bit pv, input logic [31:0] pc, input bit rv, input bit rt, input bit fl);
    @(posedge clk);
    #1;
    pred_valid = pv;
    pred_pc = pc;
    res_valid = rv;
    res_taken = rt;
    flush = fl;
    @(negedge clk);
  endtask
  task automatic do_reset();
    pred_valid = 0;
    res_valid = 0;
    flush = 0;
    rst_n = 0;
    mreset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask
  initial begin
    bit rt;
    do_reset();
    chk_en = 1;
    set_in(1, 32'h100, 0, 0, 0);
    chk("reset_taken", pred_taken, 0);
    chk("reset_sel", pred_sel, 0);
    chk("reset_ready", pred_ready, 1);
    do_reset();
    for (int k = 0; k < 12; k++) begin
      set_in(1, 32'h100, 0, 0, 0);
      if (k == 0) chk("serial_first_taken", pred_taken, 0);
      if (k == 11) begin
        chk("serial_12th_taken", pred_taken, 1);
        chk("serial_12th_sel", pred_sel, 0);
      end
      set_in(0, 32'h100, 1, 1, 0);
      if (k < 11) chk("serial_mispredict", res_mispredict, 1);
    end
    set_in(1, 32'h100, 0, 0, 0);
    set_in(1, 32'h100, 0, 0, 0);
    set_in(0, 32'h100, 0, 0, 0);
    chk("pre_reset_taken", pred_taken, 1);
    #2 rst_n = 0;
    #1;
    chk("async_reset_ready", pred_ready, 1);
    chk("async_reset_taken", pred_taken, 0);
    chk("async_reset_sel", pred_sel, 0);
    @(posedge clk);
    #1 rst_n = 1;
    for (int k = 0; k < 4; k++) set_in(1, 32'h200 + 32'(4 * k), 0, 0, 0);
    set_in(1, 32'h300, 0, 0, 0);
    chk("full_ready", pred_ready, 0);
    set_in(0, 32'h300, 1, 0, 0);
    chk("full_pop_mispredict", res_mispredict, 0);
    chk("full_no_passthrough", pred_ready, 0);
    set_in(0, 32'h300, 0, 0, 0);
    chk("after_pop_ready", pred_ready, 1);
    set_in(1, 32'h400, 0, 0, 0);
    set_in(0, 32'h400, 0, 0, 0);
    chk("refill_ready", pred_ready, 0);
    do_reset();
    for (int k = 0; k < 3; k++) set_in(1, 32'h500 + 32'(4 * k), 0, 0, 0);
    set_in(1, 32'h600, 1, 1, 0);
    chk("mis_flag", res_mispredict, 1);
    chk("mis_ready", pred_ready, 0);
    set_in(0, 32'h600, 1, 1, 0);
    chk("empty_res_mispredict", res_mispredict, 0);
    chk("empty_ready", pred_ready, 1);
    set_in(0, 32'h100, 0, 0, 0);
    chk("empty_res_taken", pred_taken, 0);
`ifdef TOURNAMENT_BPRED_STATS_EN
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(1, 32'h100, 0, 0, 0);
      set_in(0, 32'h100, 1, k % 2 == 1, 0);
    end
    set_in(0, 32'h100, 0, 0, 0);
    chk("stat_branches_5", stat_branches, 5);
    chk("stat_mispredicts_2", stat_mispredicts, 2);
`endif
    do_reset();
    repeat (4000) begin
      rt = mq.size() > 0 && mq[0].lidx % 2 == 1 ? ($urandom % 8 != 0) : ($urandom % 8 == 0);
      set_in($urandom % 4 != 0, 32'h1000 + 32'(($urandom % 16) << 2) + 32'(($urandom % 4) << 12),
             $urandom % 5 < 2, rt, $urandom % 64 == 0);
    end
    set_in(0, 32'h0, 0, 0, 0);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
